alsu_cmd_sequencer: RTL and testbench

- Initiator-side front end for the ALSU datapath.
- Accepts one ALSU operation at a time over a valid/ready command port and drives the ALSU input pins stably for a fixed window.
- Waits the ALSU pipeline latency, then captures the ALSU out and leds pins and returns a result over a valid/ready response port.
- Classifies invalid operations locally and enforces an error-recovery holdoff. Sits between the bench/CPU command stream and the ALSU instance.

---
 rtl/alsu_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_alsu_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_sequencer.sv
`timescale 1ns/1ps
// Initiator-side front end for the ALSU: drives one command at a time onto the
// ALSU pins, samples the result after the pipeline latency and returns it.
module alsu_cmd_sequencer #(
  parameter int HOLD_CYCLES    = 2,
  parameter int LATENCY        = 3,
  parameter int RECOVER_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [2:0]  cmd_a,
  input  logic [2:0]  cmd_b,
  input  logic [6:0]  cmd_ctrl,
  output logic [2:0]  alsu_a,
  output logic [2:0]  alsu_b,
  output logic [2:0]  alsu_opcode,
  output logic [6:0]  alsu_ctrl,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        rsp_leds_seen,
  output logic [7:0]  cmd_count
);

  localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LAT_LAST     = 4'(LATENCY - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);
  localparam bit         RECOVER_EN   = (RECOVER_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Opcodes 6/7 are reserved; reduction is only legal for the logic ops 0/1.
  function automatic logic is_invalid(input logic [2:0] op, input logic [6:0] ctrl);
    logic red_s;
    red_s = ctrl[3] | ctrl[2];
    case (op)
      3'd6, 3'd7:             is_invalid = 1'b1;
      3'd2, 3'd3, 3'd4, 3'd5: is_invalid = red_s;
      default:                is_invalid = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        inv_r, inv_s;
  logic        leds_seen_r, leds_seen_s;
  logic [2:0]  a_s, b_s, op_s;
  logic [6:0]  ctrl_s;
  logic        rsp_valid_s, rsp_err_s, rsp_leds_seen_s;
  logic [5:0]  rsp_data_s;
  logic [7:0]  cmd_count_s;

  assign cmd_ready = (state_r == ST_IDLE);

  // Next-state and next-output decode.
  always_comb begin
    state_s         = state_r;
    cnt_s           = cnt_r;
    inv_s           = inv_r;
    leds_seen_s     = leds_seen_r;
    a_s             = alsu_a;
    b_s             = alsu_b;
    op_s            = alsu_opcode;
    ctrl_s          = alsu_ctrl;
    rsp_valid_s     = rsp_valid;
    rsp_data_s      = rsp_data;
    rsp_err_s       = rsp_err;
    rsp_leds_seen_s = rsp_leds_seen;
    cmd_count_s     = cmd_count;
    case (state_r)
      ST_IDLE: begin
        a_s    = 3'd0;
        b_s    = 3'd0;
        op_s   = 3'd0;
        ctrl_s = 7'd0;
        if (cmd_valid) begin
          a_s     = cmd_a;
          b_s     = cmd_b;
          op_s    = cmd_opcode;
          ctrl_s  = cmd_ctrl;
          inv_s   = is_invalid(cmd_opcode, cmd_ctrl);
          cnt_s   = 4'd0;
          state_s = ST_DRIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == HOLD_LAST) begin
          cnt_s   = 4'd0;
          state_s = ST_WAIT;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_WAIT: begin
        leds_seen_s = leds_seen_r | (alsu_leds != 16'd0);
        if (cnt_r == LAT_LAST) begin
          rsp_data_s      = alsu_out;
          rsp_err_s       = inv_r | leds_seen_s;
          rsp_leds_seen_s = leds_seen_s;
          rsp_valid_s     = 1'b1;
          a_s             = 3'd0;
          b_s             = 3'd0;
          op_s            = 3'd0;
          ctrl_s          = 7'd0;
          cnt_s           = 4'd0;
          state_s         = ST_RESP;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          cmd_count_s = cmd_count + 8'd1;
          leds_seen_s = 1'b0;
          cnt_s       = 4'd0;
          if (rsp_err && RECOVER_EN) begin
            state_s = ST_RECOVER;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == RECOVER_LAST) begin
          cnt_s   = 4'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        a_s     = 3'd0;
        b_s     = 3'd0;
        op_s    = 3'd0;
        ctrl_s  = 7'd0;
        cnt_s   = 4'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      inv_r         <= 1'b0;
      leds_seen_r   <= 1'b0;
      alsu_a        <= 3'd0;
      alsu_b        <= 3'd0;
      alsu_opcode   <= 3'd0;
      alsu_ctrl     <= 7'd0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 6'd0;
      rsp_err       <= 1'b0;
      rsp_leds_seen <= 1'b0;
      cmd_count     <= 8'd0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      inv_r         <= inv_s;
      leds_seen_r   <= leds_seen_s;
      alsu_a        <= a_s;
      alsu_b        <= b_s;
      alsu_opcode   <= op_s;
      alsu_ctrl     <= ctrl_s;
      rsp_valid     <= rsp_valid_s;
      rsp_data      <= rsp_data_s;
      rsp_err       <= rsp_err_s;
      rsp_leds_seen <= rsp_leds_seen_s;
      cmd_count     <= cmd_count_s;
    end
  end

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
`timescale 1ns/1ps
// Directed bench for alsu_cmd_sequencer: a timestamp-based transaction model is
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_alsu_cmd_sequencer;

  localparam int H = 2;
  localparam int L = 3;
  localparam int R = 6;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode, cmd_a, cmd_b;
  logic [6:0]  cmd_ctrl;
  logic [2:0]  alsu_a, alsu_b, alsu_opcode;
  logic [6:0]  alsu_ctrl;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid, rsp_ready;
  logic [5:0]  rsp_data;
  logic        rsp_err, rsp_leds_seen;
  logic [7:0]  cmd_count;

  int n_checks = 0;
  int n_err    = 0;
  int hs_cnt   = 0;

  alsu_cmd_sequencer #(.HOLD_CYCLES(H), .LATENCY(L), .RECOVER_CYCLES(R)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctrl(cmd_ctrl),
    .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode), .alsu_ctrl(alsu_ctrl),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_leds_seen(rsp_leds_seen), .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: each command is described by its accept edge; everything
  // else is derived from that timestamp and the parameters.
  int         t = 0;
  int         acc_t = 0;
  int         ready_at = 0;
  bit         inflight = 1'b0;
  bit         pend = 1'b0;
  bit         m_ready = 1'b1;
  logic [2:0] m_op = 3'd0, m_a = 3'd0, m_b = 3'd0;
  logic [6:0] m_ctrl = 7'd0;
  bit         m_inv = 1'b0, m_leds = 1'b0, m_err = 1'b0, m_seen = 1'b0;
  logic [5:0] m_data = 6'd0;
  logic [7:0] m_cnt = 8'd0;
  bit         prev_rv = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      t++;
      if (!rst && prev_rv && rsp_ready) hs_cnt++;
      if (rst) begin
        inflight = 1'b0; pend = 1'b0; ready_at = 0; m_ready = 1'b1;
        m_data = 6'd0; m_err = 1'b0; m_seen = 1'b0; m_cnt = 8'd0; m_leds = 1'b0;
      end else begin
        if (pend) begin
          if (rsp_ready) begin
            pend     = 1'b0;
            m_cnt    = m_cnt + 8'd1;
            ready_at = (m_err && R > 0) ? t + R : t;
          end
        end else if (inflight) begin
          if (t > acc_t + H) m_leds = m_leds | (alsu_leds != 16'd0);
          if (t == acc_t + H + L) begin
            pend     = 1'b1;
            inflight = 1'b0;
            m_data   = alsu_out;
            m_err    = m_inv | m_leds;
            m_seen   = m_leds;
          end
        end else if (m_ready && cmd_valid) begin
          inflight = 1'b1;
          acc_t    = t;
          m_op = cmd_opcode; m_a = cmd_a; m_b = cmd_b; m_ctrl = cmd_ctrl;
          m_inv  = (cmd_opcode inside {3'd6, 3'd7}) ||
                   ((cmd_opcode inside {[3'd2:3'd5]}) && (cmd_ctrl[3] || cmd_ctrl[2]));
          m_leds = 1'b0;
        end
        m_ready = !inflight && !pend && (t >= ready_at);
      end
      #1;
      chk("cmd_ready",     32'(cmd_ready),     32'(m_ready));
      chk("alsu_a",        32'(alsu_a),        inflight ? 32'(m_a) : 32'd0);
      chk("alsu_b",        32'(alsu_b),        inflight ? 32'(m_b) : 32'd0);
      chk("alsu_opcode",   32'(alsu_opcode),   inflight ? 32'(m_op) : 32'd0);
      chk("alsu_ctrl",     32'(alsu_ctrl),     inflight ? 32'(m_ctrl) : 32'd0);
      chk("rsp_valid",     32'(rsp_valid),     32'(pend));
      chk("rsp_data",      32'(rsp_data),      32'(m_data));
      chk("rsp_err",       32'(rsp_err),       32'(m_err));
      chk("rsp_leds_seen", 32'(rsp_leds_seen), 32'(m_seen));
      chk("cmd_count",     32'(cmd_count),     32'(m_cnt));
      prev_rv = rsp_valid;
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [6:0] ctrl);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_ctrl = ctrl;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int holds;
    int k;
    int low;
    int hs0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_a = 3'd0; cmd_b = 3'd0;
    cmd_ctrl = 7'd0; alsu_out = 6'd0; alsu_leds = 16'd0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_cmd_count", 32'(cmd_count), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // AND: hold window and response latency
    alsu_out = 6'h04;
    do_cmd(3'd0, 3'd5, 3'd6, 7'd0);
    holds = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      if (alsu_a == 3'd5 && alsu_b == 3'd6 && alsu_opcode == 3'd0) holds++;
      @(negedge clk);
      k++;
    end
    chk("hold_cycles", 32'(holds), 32'd5);
    chk("rsp_first_sampled_edge", 32'(k + 1), 32'd6);
    chk("and_rsp_data", 32'(rsp_data), 32'h04);
    chk("and_rsp_err", 32'(rsp_err), 32'd0);
    chk("alsu_zero_in_resp", 32'(alsu_a), 32'd0);
    @(negedge clk);
    chk("and_cmd_count", 32'(cmd_count), 32'd1);
    chk("and_ready_next", 32'(cmd_ready), 32'd1);

    // Invalid opcode with leds activity, then recovery length
    alsu_leds = 16'hFFFF;
    alsu_out  = 6'h3F;
    do_cmd(3'd7, 3'd1, 3'd2, 7'd0);
    wait_rsp();
    chk("inv_rsp_err", 32'(rsp_err), 32'd1);
    chk("inv_leds_seen", 32'(rsp_leds_seen), 32'd1);
    @(negedge clk);
    alsu_leds = 16'd0;
    low = 0;
    while (!cmd_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    chk("recover_low_cycles", 32'(low), 32'd6);

    // Reduction on an arithmetic opcode
    alsu_out = 6'h11;
    do_cmd(3'd2, 3'd3, 3'd1, 7'b0001000);
    wait_rsp();
    chk("red_rsp_err", 32'(rsp_err), 32'd1);
    chk("red_leds_seen", 32'(rsp_leds_seen), 32'd0);
    @(negedge clk);
    chk("red_recover_entered", 32'(cmd_ready), 32'd0);

    // Response backpressure with ignored command pulses
    rsp_ready = 1'b0;
    alsu_out  = 6'h2A;
    do_cmd(3'd1, 3'd3, 3'd4, 7'd0);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h2A);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = (i % 2) == 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", 32'(rsp_valid), 32'd0);
    chk("bp_cmd_count", 32'(cmd_count), 32'd4);
    chk("bp_ready_after", 32'(cmd_ready), 32'd1);

    // Reset during WAIT
    alsu_out = 6'h15;
    do_cmd(3'd0, 3'd7, 3'd7, 7'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_alsu_a", 32'(alsu_a), 32'd0);
    chk("rst_alsu_b", 32'(alsu_b), 32'd0);
    chk("rst_alsu_opcode", 32'(alsu_opcode), 32'd0);
    chk("rst_alsu_ctrl", 32'(alsu_ctrl), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    do_cmd(3'd3, 3'd2, 3'd1, 7'd0);
    wait_rsp();
    chk("post_rst_data", 32'(rsp_data), 32'h15);
    @(negedge clk);
    chk("post_rst_count", 32'(cmd_count), 32'd1);

    // 257 commands: counter wrap and handshake accounting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    alsu_out = 6'h09;
    hs0 = hs_cnt;
    for (int i = 0; i < 257; i++) begin
      do_cmd(3'(i % 6), 3'(i), 3'(i + 3), 7'd0);
    end
    wait_rsp();
    @(negedge clk);
    chk("wrap_handshakes", 32'(hs_cnt - hs0), 32'd257);
    chk("wrap_cmd_count", 32'(cmd_count), 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
